// File: rtl/seq_div_16.sv
// seq_div_16: multi-cycle signed integer divider, radix-2 restoring, one
// quotient bit per clock. Quotient truncates toward zero and the remainder
// takes the sign of the dividend, the same as Verilog signed "/" and "%".
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request; accepted only while ready=1
//   A, B       signed dividend / divisor, sampled on the accept edge
//   ready      1 in IDLE and DONE (a start would be accepted)
//   busy       1 while iterating
//   done       one-cycle pulse, results valid
//   quotient   signed quotient, held until the next accepted start completes
//   remainder  signed remainder, held like quotient
//   div0       divide-by-zero flag, valid with done, cleared on next accept
module seq_div_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]     prem_q, prem_d;   // partial remainder, one guard bit
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // |A| shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_q, dvs_d;     // |B|
    logic               sign_q_q, sign_q_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               div0_q, div0_d;

    // Magnitudes of the operands; |most-negative| fits as an unsigned value.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
    assign b_mag = B[WIDTH-1] ? (WIDTH'(0) - B) : B;

    // One restoring step: shift in the next dividend bit, trial subtract |B|.
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] dvd_next;

    assign trial     = {prem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
    assign qbit      = ~trial[WIDTH+1];
    assign prem_next = qbit ? trial[WIDTH:0] : {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign dvd_next  = {dvd_q[WIDTH-2:0], qbit};

    logic accept;
    assign accept = start && ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prem_d   = prem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div0_d   = div0_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
                    sign_r_d = A[WIDTH-1];
                    dvd_d    = a_mag;
                    dvs_d    = b_mag;
                    prem_d   = '0;
                    cnt_d    = '0;
                    if (B == '0) begin
                        // No iterations: report all-ones quotient and echo A.
                        quot_d  = '1;
                        rem_d   = A;
                        div0_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        div0_d  = 1'b0;
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                prem_d = prem_next;
                dvd_d  = dvd_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    quot_d  = sign_q_q ? (WIDTH'(0) - dvd_next) : dvd_next;
                    rem_d   = sign_r_q ? (WIDTH'(0) - prem_next[WIDTH-1:0])
                                       : prem_next[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prem_q   <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prem_q   <= prem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div0_q   <= div0_d;
        end
    end

    // Status decodes straight from the state register.
    assign ready     = (state_q != StIter);
    assign busy      = (state_q == StIter);
    assign done      = (state_q == StDone);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_seq_div_16.sv
// Self-checking bench for seq_div_16: table of directed vectors, hand-written
// handshake/reset sequences, and a signed operand sweep against "/" and "%".
module tb_seq_div_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] A, B;
    logic        ready, busy, done, div0;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_div_16 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(int a, int b, int q, int r, bit z);
        vec_t v;
        v.a = 16'(a);
        v.b = 16'(b);
        v.q = 16'(q);
        v.r = 16'(r);
        v.z = z;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request (start high for one cycle) and wait for done.
    // lat counts negedge samples after the accept edge; bsy counts busy samples.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int bsy);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 16'h5a5a;
        B     = 16'h0003;
        lat   = 1;
        bsy   = 0;
        while (!done && lat < 40) begin
            if (busy) bsy++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done: got 0 expected 1");
        end
    endtask

    int lat, bsy, saw_done;
    logic [15:0] eq, er;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        tbl[0] = mk(100, 7, 14, 2, 1'b0);
        tbl[1] = mk(-100, 7, -14, -2, 1'b0);
        tbl[2] = mk(100, -7, -14, 2, 1'b0);
        tbl[3] = mk(-100, -7, 14, -2, 1'b0);
        tbl[4] = mk(-32768, -1, -32768, 0, 1'b0);
        tbl[5] = mk(-32768, 1, -32768, 0, 1'b0);
        tbl[6] = mk(32767, -32768, 0, 32767, 1'b0);
        tbl[7] = mk(5, 9, 0, 5, 1'b0);
        tbl[8] = mk(1234, 0, 16'hffff, 1234, 1'b1);
        tbl[9] = mk(9, 3, 3, 0, 1'b0);

        // Reset state
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat, bsy);
            chk($sformatf("v%0d_quot", i), 32'(quotient), 32'(tbl[i].q));
            chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(tbl[i].r));
            chk($sformatf("v%0d_div0", i), 32'(div0), 32'(tbl[i].z));
            chk($sformatf("v%0d_latency", i), 32'(lat), (tbl[i].b == 0) ? 32'd1 : 32'd17);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bsy), (tbl[i].b == 0) ? 32'd0 : 32'd16);
            chk($sformatf("v%0d_ready_at_done", i), 32'(ready), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // start pulsed mid-ITER with other operands is ignored: 1000/3
        A = 16'd1000;
        B = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        A = 16'd7;
        B = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'd0;
        B = 16'd0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_done_seen", 32'(done), 32'd1);
        chk("ign_latency", 32'(lat), 32'd10);
        chk("ign_quot", 32'(quotient), 32'd333);
        chk("ign_rem", 32'(remainder), 32'd1);
        @(negedge clk);
        chk("ign_no_second_done", 32'(done), 32'd0);
        @(negedge clk);

        // start held across DONE: 50/6 then 20/-3 back to back
        A = 16'd50;
        B = 16'd6;
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd17);
        chk("b2b_first_quot", 32'(quotient), 32'd8);
        chk("b2b_first_rem", 32'(remainder), 32'd2);
        A = 16'd20;
        B = 16'hfffd;
        @(negedge clk);
        chk("b2b_done_drops", 32'(done), 32'd0);
        chk("b2b_second_busy", 32'(busy), 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd17);
        chk("b2b_second_quot", 32'(quotient), 32'hfffa);
        chk("b2b_second_rem", 32'(remainder), 32'd2);
        @(negedge clk);

        // Back-to-back divide-by-zero: one done pulse per request
        A = 16'd77;
        B = 16'd0;
        start = 1'b1;
        @(negedge clk);
        chk("z2_first_done", 32'(done), 32'd1);
        A = 16'hfff0;
        @(negedge clk);
        start = 1'b0;
        chk("z2_second_done", 32'(done), 32'd1);
        chk("z2_second_rem", 32'(remainder), 32'hfff0);
        chk("z2_second_div0", 32'(div0), 32'd1);
        @(negedge clk);
        chk("z2_done_ends", 32'(done), 32'd0);

        // Async reset at iteration 8 of 100/7
        A = 16'd100;
        B = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quot", 32'(quotient), 32'd0);
        chk("arst_rem", 32'(remainder), 32'd0);
        chk("arst_div0", 32'(div0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("arst_no_done", 32'(saw_done), 32'd0);

        // Signed sweep against the language operators
        for (int n = 0; n < 590; n++) begin
            int ia, jb;
            ia = -32768 + 111 * n;
            jb = -32768 + 285 * ((n * 37) % 230);
            if (jb == 0) continue;
            eq = 16'(ia / jb);
            er = 16'(ia % jb);
            run_op(16'(ia), 16'(jb), lat, bsy);
            chk($sformatf("sweep_quot %0d/%0d", ia, jb), 32'(quotient), 32'(eq));
            chk($sformatf("sweep_rem %0d%%%0d", ia, jb), 32'(remainder), 32'(er));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
